// File: rtl/seven_segment_capture.sv
// ---------------------------------------------------------------------------
// seven_segment_capture
//   Receive side of a 4-digit multiplexed seven-segment display. Samples the
//   active-low anode strobes and segment lines, decodes each stable digit back
//   to a BCD nibble and emits a 16-bit frame once all four digits are captured.
//
//   Optional build macro: SEG_CAPTURE_HEX_EN -- also decode A..F glyphs.
//
// Parameters
//   SETTLE_CYCLES  consecutive identical valid samples to accept a digit (1..15)
// Ports
//   clk          system clock, posedge
//   rst_n        synchronous reset, active-low
//   seg_in[6:0]  segment lines, active-low, bit0=a .. bit6=g
//   an_in[3:0]   anode strobes, active-low, 1110=digit0 .. 0111=digit3
//   data_out     last complete frame, digit k at [4k+3:4k]
//   digit_err    per-digit decode error for the frame in data_out
//   frame_valid  one-cycle pulse when data_out/digit_err update
//   proto_err    sticky multi-hot anode flag, cleared only by reset
// ---------------------------------------------------------------------------
module seven_segment_capture #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] data_out,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        proto_err
);

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  logic [3:0]  r_s_an;
  logic [6:0]  r_s_seg;
  logic [3:0]  r_prev_an;
  logic [6:0]  r_prev_seg;
  logic [3:0]  r_cnt;
  logic        r_acc_done;
  logic [3:0]  r_mask;
  logic [15:0] r_sh_data;
  logic [3:0]  r_sh_err;

  logic        w_valid;
  logic        w_bad;
  logic [1:0]  w_idx;
  logic        w_same;
  logic        w_an_changed;
  logic [3:0]  w_cnt_next;
  logic        w_accept;
  logic        w_frame;
  logic [3:0]  w_mask_next;
  logic [4:0]  w_dec;

  // Returns {error, nibble}.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = {1'b1, 4'hF};
    case (seg)
      7'h40: res = {1'b0, 4'h0};
      7'h79: res = {1'b0, 4'h1};
      7'h24: res = {1'b0, 4'h2};
      7'h30: res = {1'b0, 4'h3};
      7'h19: res = {1'b0, 4'h4};
      7'h12: res = {1'b0, 4'h5};
      7'h02: res = {1'b0, 4'h6};
      7'h78: res = {1'b0, 4'h7};
      7'h00: res = {1'b0, 4'h8};
      7'h10: res = {1'b0, 4'h9};
`ifdef SEG_CAPTURE_HEX_EN
      7'h08: res = {1'b0, 4'hA};
      7'h03: res = {1'b0, 4'hB};
      7'h46: res = {1'b0, 4'hC};
      7'h21: res = {1'b0, 4'hD};
      7'h06: res = {1'b0, 4'hE};
      7'h0E: res = {1'b0, 4'hF};
`else
`endif
      default: res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  always_comb begin
    w_valid = 1'b1;
    w_idx   = 2'd0;
    case (r_s_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_bad        = !w_valid && (r_s_an != 4'b1111);
  assign w_same       = ({r_s_an, r_s_seg} == {r_prev_an, r_prev_seg});
  assign w_an_changed = (r_s_an != r_prev_an);
  assign w_dec        = f_decode(r_s_seg);
  assign w_frame      = (r_mask == 4'b1111);

  always_comb begin
    w_cnt_next = 4'd0;
    if (w_valid && w_same)
      w_cnt_next = (r_cnt == LP_SETTLE) ? r_cnt : 4'(r_cnt + 4'd1);
    else if (w_valid)
      w_cnt_next = 4'd1;
  end

  // The done flag only blocks a re-accept within the same strobe window; a new
  // anode value starts a fresh window even when SETTLE_CYCLES is 1.
  assign w_accept = w_valid && (w_cnt_next == LP_SETTLE) &&
                    (!r_acc_done || w_an_changed);

  // Frame completion clears the mask first so a coincident accept lands in
  // the next frame.
  always_comb begin
    w_mask_next = r_mask;
    if (w_frame || w_bad)
      w_mask_next = '0;
    if (w_accept)
      w_mask_next[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_an      <= '1;
      r_s_seg     <= '1;
      r_prev_an   <= '1;
      r_prev_seg  <= '1;
      r_cnt       <= '0;
      r_acc_done  <= 1'b0;
      r_mask      <= '0;
      r_sh_data   <= '0;
      r_sh_err    <= '0;
      data_out    <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      r_s_an     <= an_in;
      r_s_seg    <= seg_in;
      r_prev_an  <= r_s_an;
      r_prev_seg <= r_s_seg;
      r_cnt      <= w_cnt_next;
      r_mask     <= w_mask_next;

      if (w_accept)
        r_acc_done <= 1'b1;
      else if (!w_valid || w_an_changed)
        r_acc_done <= 1'b0;

      if (w_accept) begin
        r_sh_data[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
        r_sh_err[w_idx]                <= w_dec[4];
      end

      frame_valid <= w_frame;
      if (w_frame) begin
        data_out  <= r_sh_data;
        digit_err <= r_sh_err;
      end

      if (w_bad)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] data_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  logic [15:0] obs_d[$];
  logic [3:0]  obs_e[$];

  seven_segment_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .data_out(data_out), .digit_err(digit_err),
    .frame_valid(frame_valid), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      fv_count++;
      obs_d.push_back(data_out);
      obs_e.push_back(digit_err);
    end
  end

  // Glyph table: index = value, 0-9 always, A-F only with the hex build.
  logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG_CAPTURE_HEX_EN
  localparam int NGLYPH = 16;
`else
  localparam int NGLYPH = 10;
`endif

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < NGLYPH; i++)
      if (PAT[i] == s) return {1'b0, 4'(i)};
    return {1'b1, 4'hF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input int k, input logic [6:0] seg, input int len);
    an_in  = ~(4'b0001 << k);
    seg_in = seg;
    repeat (len) step();
    an_in  = 4'hF;
    seg_in = 7'h7F;
    step();
  endtask

  task automatic send_frame(input logic [27:0] segs);
    for (int k = 0; k < 4; k++) send_digit(k, segs[7*k +: 7], 4);
    repeat (3) step();
  endtask

  typedef struct {
    string       name;
    logic [27:0] segs;
    logic [15:0] exp_data;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs[4];
  logic [3:0] bads[8] = '{4'b1100, 4'b0000, 4'b1010, 4'b0101,
                          4'b0011, 4'b1001, 4'b0110, 4'b1000};

  initial begin
    int n0;
    vecs[0] = '{"v1234", {7'h19, 7'h30, 7'h24, 7'h79}, 16'h4321, 4'b0000};
    vecs[1] = '{"vblank", {7'h10, 7'h7F, 7'h12, 7'h40}, 16'h9F50, 4'b0100};
    vecs[2] = '{"v6780", {7'h40, 7'h00, 7'h78, 7'h02}, 16'h0876, 4'b0000};
`ifdef SEG_CAPTURE_HEX_EN
    vecs[3] = '{"vhex", {7'h30, 7'h19, 7'h03, 7'h08}, 16'h34BA, 4'b0000};
`else
    vecs[3] = '{"vhex", {7'h30, 7'h19, 7'h03, 7'h08}, 16'h34FF, 4'b0011};
`endif

    // Reset with random inputs.
    rst_n = 1'b0;
    repeat (2) begin
      an_in = 4'($urandom); seg_in = 7'($urandom);
      step();
    end
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_proto", 32'(proto_err), 32'h0);
    an_in = 4'hF; seg_in = 7'h7F;
    step();
    rst_n = 1'b1;
    step();

    // Table-driven frames.
    foreach (vecs[i]) begin
      n0 = fv_count;
      send_frame(vecs[i].segs);
      chk({vecs[i].name, "_nfv"}, 32'(fv_count - n0), 32'd1);
      chk({vecs[i].name, "_data"}, 32'(data_out), 32'(vecs[i].exp_data));
      chk({vecs[i].name, "_err"}, 32'(digit_err), 32'(vecs[i].exp_err));
    end
    chk("proto_clean", 32'(proto_err), 32'h0);

    // Earliest frame_valid latency for the last digit.
    for (int k = 0; k < 3; k++) send_digit(k, PAT[k + 5], 4);
    an_in = 4'b0111; seg_in = 7'h40;
    repeat (3) step();
    chk("lat_early", 32'(frame_valid), 32'h0);
    step();
    chk("lat_on", 32'(frame_valid), 32'h1);
    chk("lat_data", 32'(data_out), 32'h0765);
    step();
    chk("lat_pulse", 32'(frame_valid), 32'h0);
    an_in = 4'hF; seg_in = 7'h7F;
    repeat (2) step();

    // Unstable digit1 window never accepts.
    n0 = fv_count;
    send_digit(0, 7'h40, 4);
    an_in = 4'b1101;
    for (int c = 0; c < 6; c++) begin
      seg_in = (c % 2 == 0) ? 7'h24 : 7'h30;
      step();
    end
    an_in = 4'hF; step();
    send_digit(2, 7'h24, 4);
    send_digit(3, 7'h30, 4);
    repeat (4) step();
    chk("tog_nofv", 32'(fv_count - n0), 32'd0);
    send_digit(1, 7'h79, 4);
    repeat (3) step();
    chk("tog_nfv", 32'(fv_count - n0), 32'd1);
    chk("tog_data", 32'(data_out), 32'h3210);

    // Multi-hot strobe discards a partial frame.
    n0 = fv_count;
    send_digit(0, 7'h12, 4);
    send_digit(1, 7'h02, 4);
    an_in = 4'b1100; seg_in = 7'h40; step();
    an_in = 4'hF; step();
    send_frame({7'h78, 7'h40, 7'h10, 7'h00});
    chk("bad_proto", 32'(proto_err), 32'h1);
    chk("bad_nfv", 32'(fv_count - n0), 32'd1);
    chk("bad_data", 32'(data_out), 32'h7098);

    // Reset mid-frame.
    send_digit(0, 7'h40, 4);
    send_digit(1, 7'h79, 4);
    rst_n = 1'b0; repeat (2) step();
    chk("mrst_data", 32'(data_out), 32'h0);
    chk("mrst_proto", 32'(proto_err), 32'h0);
    rst_n = 1'b1; step();
    n0 = fv_count;
    send_digit(2, 7'h24, 4);
    send_digit(3, 7'h30, 4);
    repeat (3) step();
    chk("mrst_nofv", 32'(fv_count - n0), 32'd0);
    send_digit(0, 7'h19, 4);
    send_digit(1, 7'h12, 4);
    repeat (3) step();
    chk("mrst_nfv", 32'(fv_count - n0), 32'd1);
    chk("mrst_data2", 32'(data_out), 32'h3254);

    // Randomized windows against a window-level model.
    begin
      logic [3:0]  m_mask;
      logic [15:0] m_d;
      logic [3:0]  m_e;
      logic        m_proto;
      logic [15:0] exp_d[$];
      logic [3:0]  exp_e[$];
      rst_n = 1'b0; repeat (2) step();
      rst_n = 1'b1; step();
      obs_d.delete(); obs_e.delete();
      m_mask = '0; m_d = '0; m_e = '0; m_proto = 1'b0;
      for (int w = 0; w < 80; w++) begin
        if ($urandom_range(0, 9) == 0) begin
          an_in = bads[$urandom_range(0, 7)];
          seg_in = 7'($urandom);
          repeat ($urandom_range(1, 2)) step();
          m_mask = '0; m_proto = 1'b1;
        end else begin
          int k, len, sel;
          logic [6:0] s;
          logic [4:0] dec;
          k = $urandom_range(0, 3);
          len = $urandom_range(1, 5);
          sel = $urandom_range(0, 19);
          if (sel < 12) s = PAT[$urandom_range(0, 9)];
          else if (sel < 15) s = PAT[$urandom_range(10, 15)];
          else s = 7'($urandom);
          an_in = ~(4'b0001 << k); seg_in = s;
          repeat (len) step();
          if (len >= SETTLE) begin
            dec = ref_dec(s);
            m_d[4*k +: 4] = dec[3:0];
            m_e[k] = dec[4];
            m_mask[k] = 1'b1;
            if (m_mask == 4'hF) begin
              exp_d.push_back(m_d); exp_e.push_back(m_e);
              m_mask = '0;
            end
          end
        end
        an_in = 4'hF; seg_in = 7'($urandom);
        repeat ($urandom_range(1, 2)) step();
      end
      repeat (4) step();
      chk("rnd_nframes", 32'(obs_d.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
        chk($sformatf("rnd_data%0d", i), 32'(obs_d[i]), 32'(exp_d[i]));
        chk($sformatf("rnd_err%0d", i), 32'(obs_e[i]), 32'(exp_e[i]));
      end
      chk("rnd_proto", 32'(proto_err), 32'(m_proto));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
